// File: rtl/llsc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : llsc_ctrl
// Purpose  : LL/SC reservation controller at the MEM/WB boundary. Tracks one
//            reservation, resolves SC outcome, drives CP0 LLbit/LLAddr.
//            Optional reservation timeout: define LLSC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module llsc_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int GRAN_LSB = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              mem_ll_i,
  input  logic              mem_sc_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              snoop_we_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              sc_ok_o,
  output logic              llbit_o,
  output logic [ADDR_W-1:0] lladdr_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LL_PEND = 2'd1,
    RESV    = 2'd2
  } state_t;

  // Granule mask: compare only the address bits above GRAN_LSB.
  localparam logic [ADDR_W-1:0] GMASK = {ADDR_W{1'b1}} << GRAN_LSB;

  state_t state, state_next;
  logic   sc_acc, ll_acc, mem_match, snoop_match, snoop_hit, timeout_hit;

  assign sc_acc      = mem_sc_i & ~stall & ~flush;
  assign ll_acc      = mem_ll_i & ~mem_sc_i & ~stall & ~flush;
  assign mem_match   = ((mem_addr_i ^ lladdr_o) & GMASK) == '0;
  assign snoop_match = ((snoop_addr_i ^ lladdr_o) & GMASK) == '0;
  assign snoop_hit   = snoop_we_i & snoop_match & (state != IDLE);
  assign sc_ok_o     = sc_acc & ((state == RESV) | (state == LL_PEND))
                     & mem_match & ~snoop_hit;

`ifdef LLSC_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0] cnt;

  assign timeout_hit = (state == RESV) && (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state != RESV && state_next == RESV) begin
      cnt <= '0;
    end else if (state == RESV && state_next == RESV && !stall) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else if (sc_acc) begin
      state_next = IDLE;
    end else if (ll_acc) begin
      state_next = LL_PEND;
    end else if (snoop_hit) begin
      state_next = IDLE;
    end else if (state == LL_PEND) begin
      state_next = RESV;
    end else if (timeout_hit) begin
      state_next = IDLE;
    end
  end

  // lladdr_o is CP0-readable, so only an accepted LL may change it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      llbit_o  <= 1'b0;
      lladdr_o <= '0;
    end else begin
      state   <= state_next;
      llbit_o <= (state_next == RESV);
      if (ll_acc) begin
        lladdr_o <= mem_addr_i;
      end
    end
  end

endmodule
`default_nettype wire
